// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter feeding CP0: picks the highest-priority MEM-stage event,
// emits a one-cycle cause/EPC/flush/redirect pulse and tracks exception nesting depth.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int unsigned DEPTH_MAX    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_in,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        exc_sys,
    input  logic        exc_unimpl,
    input  logic        exc_ovf,
    input  logic        eret_in,
    input  logic        pipe_stall,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    output logic [3:0]  sig_out,
    output logic        epc_wr,
    output logic [31:0] epc_val,
    output logic        eret_out,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        irq_pending,
    output logic [2:0]  depth,
    output logic        nest_ovf
);

    typedef enum logic [1:0] {IDLE, TAKE, ERET} state_t;

    localparam logic [2:0] DepthMax = 3'(DEPTH_MAX);

    state_t      state_q, state_d;
    logic        irqMeta_q, irqSync_q, irqPrev_q;
    logic        pending_q, pending_d;
    logic [2:0]  depth_q, depth_d;
    logic        nestOvf_q, nestOvf_d;
    logic [3:0]  sig_q, sig_d;
    logic [31:0] epcVal_q, epcVal_d;
    logic [31:0] eretPc_q, eretPc_d;

    logic        irqEdge;
    logic        evalOk;
    logic        intReq;
    logic        takeEntry;
    logic        unusedStatus;

    assign irqEdge      = irqSync_q & ~irqPrev_q;
    assign evalOk       = (state_q == IDLE) && mem_valid && !pipe_stall;
    assign intReq       = pending_q & status_in[0];
    assign unusedStatus = ^status_in[31:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            irqMeta_q <= 1'b0;
            irqSync_q <= 1'b0;
            irqPrev_q <= 1'b0;
            pending_q <= 1'b0;
            depth_q   <= 3'd0;
            nestOvf_q <= 1'b0;
            sig_q     <= 4'd0;
            epcVal_q  <= 32'd0;
            eretPc_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            irqMeta_q <= irq_in;
            irqSync_q <= irqMeta_q;
            irqPrev_q <= irqSync_q;
            pending_q <= pending_d;
            depth_q   <= depth_d;
            nestOvf_q <= nestOvf_d;
            sig_q     <= sig_d;
            epcVal_q  <= epcVal_d;
            eretPc_q  <= eretPc_d;
        end
    end

    // Priority chain: ovf > unimpl > sys > eret > interrupt; TAKE/ERET ignore all inputs.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | irqEdge;
        depth_d   = depth_q;
        nestOvf_d = nestOvf_q;
        sig_d     = sig_q;
        epcVal_d  = epcVal_q;
        eretPc_d  = eretPc_q;
        takeEntry = 1'b0;
        case (state_q)
            IDLE: begin
                if (evalOk) begin
                    if (exc_ovf) begin
                        takeEntry = 1'b1;
                        sig_d     = 4'b1000;
                        epcVal_d  = mem_pc;
                    end else if (exc_unimpl) begin
                        takeEntry = 1'b1;
                        sig_d     = 4'b0100;
                        epcVal_d  = mem_pc;
                    end else if (exc_sys) begin
                        takeEntry = 1'b1;
                        sig_d     = 4'b0010;
                        epcVal_d  = mem_pc + 32'd4;
                    end else if (eret_in) begin
                        state_d  = ERET;
                        eretPc_d = epc_in;
                        if (depth_q != 3'd0) begin
                            depth_d = depth_q - 3'd1;
                        end
                    end else if (intReq) begin
                        takeEntry = 1'b1;
                        sig_d     = 4'b0001;
                        epcVal_d  = mem_pc;
                        pending_d = 1'b0;
                    end
                end
                if (takeEntry) begin
                    state_d = TAKE;
                    if (depth_q == DepthMax) begin
                        nestOvf_d = 1'b1;
                    end else begin
                        depth_d = depth_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sig_out     = 4'd0;
        epc_wr      = 1'b0;
        epc_val     = 32'd0;
        eret_out    = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        case (state_q)
            TAKE: begin
                sig_out     = sig_q;
                epc_wr      = 1'b1;
                epc_val     = epcVal_q;
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = HANDLER_ADDR;
            end
            ERET: begin
                eret_out    = 1'b1;
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = eretPc_q;
            end
            default: ;
        endcase
    end

    assign irq_pending = pending_q;
    assign depth       = depth_q;
    assign nest_ovf    = nestOvf_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the arbiter rules.
module tb_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        irq_in;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        exc_sys;
    logic        exc_unimpl;
    logic        exc_ovf;
    logic        eret_in;
    logic        pipe_stall;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic [3:0]  sig_out;
    logic        epc_wr;
    logic [31:0] epc_val;
    logic        eret_out;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irq_pending;
    logic [2:0]  depth;
    logic        nest_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          irqHist[$];
    bit          mBusy;
    bit          mPending;
    int          mDepth;
    bit          mNest;
    logic [3:0]  eSig;
    logic        eEpcWr;
    logic [31:0] eEpcVal;
    logic        eEret;
    logic        eFlush;
    logic        eRedir;
    logic [31:0] eRedirPc;

    exc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .mem_valid   (mem_valid),
        .mem_pc      (mem_pc),
        .exc_sys     (exc_sys),
        .exc_unimpl  (exc_unimpl),
        .exc_ovf     (exc_ovf),
        .eret_in     (eret_in),
        .pipe_stall  (pipe_stall),
        .status_in   (status_in),
        .epc_in      (epc_in),
        .sig_out     (sig_out),
        .epc_wr      (epc_wr),
        .epc_val     (epc_val),
        .eret_out    (eret_out),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_pending (irq_pending),
        .depth       (depth),
        .nest_ovf    (nest_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [76:0] dutVec();
        return {sig_out, epc_wr, epc_val, eret_out, flush, redirect, redirect_pc,
                irq_pending, depth, nest_ovf};
    endfunction

    function automatic logic [76:0] expVec();
        return {eSig, eEpcWr, eEpcVal, eEret, eFlush, eRedir, eRedirPc,
                mPending, 3'(mDepth), mNest};
    endfunction

    task automatic modelReset();
        irqHist  = '{0, 0, 0, 0};
        mBusy    = 0;
        mPending = 0;
        mDepth   = 0;
        mNest    = 0;
        eSig     = '0;
        eEpcWr   = 0;
        eEpcVal  = '0;
        eEret    = 0;
        eFlush   = 0;
        eRedir   = 0;
        eRedirPc = '0;
    endtask

    // One rising edge of the model: an interrupt edge becomes pending three samples later.
    task automatic modelEdge();
        bit edgeSeen;
        int kind;
        irqHist.push_front(irq_in);
        if (irqHist.size() > 4) void'(irqHist.pop_back());
        edgeSeen = irqHist[2] && !irqHist[3];
        eSig = '0; eEpcWr = 0; eEpcVal = '0; eEret = 0; eFlush = 0; eRedir = 0; eRedirPc = '0;
        kind = 0;
        if (mBusy) begin
            mBusy = 0;
        end else if (mem_valid && !pipe_stall) begin
            if (exc_ovf) begin
                kind = 1; eSig = 4'b1000; eEpcVal = mem_pc;
            end else if (exc_unimpl) begin
                kind = 1; eSig = 4'b0100; eEpcVal = mem_pc;
            end else if (exc_sys) begin
                kind = 1; eSig = 4'b0010; eEpcVal = mem_pc + 32'd4;
            end else if (eret_in) begin
                kind = 2;
            end else if (mPending && status_in[0]) begin
                kind = 3; eSig = 4'b0001; eEpcVal = mem_pc;
            end
        end
        if (kind == 1 || kind == 3) begin
            mBusy = 1; eEpcWr = 1; eFlush = 1; eRedir = 1; eRedirPc = 32'h80;
            if (mDepth == 7) mNest = 1;
            else mDepth = mDepth + 1;
        end else if (kind == 2) begin
            mBusy = 1; eEret = 1; eFlush = 1; eRedir = 1; eRedirPc = epc_in;
            if (mDepth > 0) mDepth = mDepth - 1;
        end
        if (kind == 3) mPending = 0;
        else mPending = mPending | edgeSeen;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        irq_in = 0; mem_valid = 0; mem_pc = '0; exc_sys = 0; exc_unimpl = 0;
        exc_ovf = 0; eret_in = 0; pipe_stall = 0; status_in = '0; epc_in = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1;
        modelReset();
        #3;
        checks++;
        if (dutVec() !== 77'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", dutVec(), 77'd0);
        end
        @(negedge clk);
        rst = 0;
        step();
        checks++;
        if (dutVec() !== expVec()) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_overflow();
        doReset();
        mem_valid = 1; mem_pc = 32'h100; exc_ovf = 1;
        step();
        checks++;
        if (dutVec() !== expVec()) begin
            errors++;
            $display("FAIL ovf_take: got %h want %h", dutVec(), expVec());
        end
        checks++;
        if ({sig_out, epc_val, redirect_pc, depth} !== {4'b1000, 32'h100, 32'h80, 3'd1}) begin
            errors++;
            $display("FAIL ovf_fields: got sig=%b epc=%h pc=%h depth=%0d", sig_out, epc_val, redirect_pc, depth);
        end
        clearInputs();
        step();
        checks++;
        if (dutVec() !== expVec()) begin
            errors++;
            $display("FAIL ovf_return_idle: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_syscall_eret();
        doReset();
        mem_valid = 1; mem_pc = 32'h200; exc_sys = 1;
        step();
        checks++;
        if (dutVec() !== expVec() || epc_val !== 32'h204 || sig_out !== 4'b0010) begin
            errors++;
            $display("FAIL sys_take: got %h want %h", dutVec(), expVec());
        end
        clearInputs();
        step();
        mem_valid = 1; eret_in = 1; epc_in = 32'h204;
        step();
        checks++;
        if (dutVec() !== expVec() || eret_out !== 1'b1 || redirect_pc !== 32'h204 || depth !== 3'd0) begin
            errors++;
            $display("FAIL eret_take: got %h want %h", dutVec(), expVec());
        end
        clearInputs();
        step();
        checks++;
        if (dutVec() !== expVec()) begin
            errors++;
            $display("FAIL eret_return_idle: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_irq_gating();
        doReset();
        mem_valid = 1; mem_pc = 32'h300;
        irq_in = 1;
        step();
        irq_in = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("FAIL irq_gated_cycle%0d: got %h want %h", i, dutVec(), expVec());
            end
        end
        checks++;
        if (irq_pending !== 1'b1 || sig_out !== 4'd0) begin
            errors++;
            $display("FAIL irq_held: got pending=%b sig=%b want pending=1 sig=0", irq_pending, sig_out);
        end
        status_in = 32'h1;
        step();
        checks++;
        if (dutVec() !== expVec() || sig_out !== 4'b0001 || epc_val !== 32'h300 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_take: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        mem_valid = 1; mem_pc = 32'h400; exc_ovf = 1; exc_sys = 1; exc_unimpl = 1;
        step();
        checks++;
        if (dutVec() !== expVec() || sig_out !== 4'b1000) begin
            errors++;
            $display("FAIL multi_exc: got %h want %h", dutVec(), expVec());
        end
        clearInputs();
        status_in = 32'h1;
        irq_in = 1;
        repeat (4) step();
        mem_valid = 1; eret_in = 1; epc_in = 32'h500;
        step();
        checks++;
        if (dutVec() !== expVec() || eret_out !== 1'b1 || irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL irq_vs_eret: got %h want %h", dutVec(), expVec());
        end
        eret_in = 0; mem_valid = 0;
        step();
        mem_valid = 1; mem_pc = 32'h600;
        step();
        checks++;
        if (dutVec() !== expVec() || sig_out !== 4'b0001) begin
            errors++;
            $display("FAIL irq_after_eret: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_stall();
        doReset();
        mem_valid = 1; mem_pc = 32'h700; exc_ovf = 1; pipe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dutVec() !== expVec() || flush !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h want %h", i, dutVec(), expVec());
            end
        end
        pipe_stall = 0;
        step();
        checks++;
        if (dutVec() !== expVec() || sig_out !== 4'b1000) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", dutVec(), expVec());
        end
    endtask

    task automatic test_nesting();
        doReset();
        mem_valid = 1; exc_sys = 1;
        for (int i = 0; i < 16; i++) begin
            mem_pc = 32'h1000 + 32'(i * 4);
            step();
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("FAIL nest_step%0d: got %h want %h", i, dutVec(), expVec());
            end
        end
        checks++;
        if (depth !== 3'd7 || nest_ovf !== 1'b1) begin
            errors++;
            $display("FAIL nest_saturate: got depth=%0d ovf=%b want depth=7 ovf=1", depth, nest_ovf);
        end
        step();
        clearInputs();
        rst = 1;
        #1;
        modelReset();
        checks++;
        if (dutVec() !== 77'd0) begin
            errors++;
            $display("FAIL reset_mid_take: got %h want %h", dutVec(), 77'd0);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 1500; i++) begin
            mem_valid  = ($urandom_range(0, 9) < 7);
            pipe_stall = ($urandom_range(0, 9) == 0);
            exc_ovf    = ($urandom_range(0, 15) == 0);
            exc_unimpl = ($urandom_range(0, 15) == 0);
            exc_sys    = ($urandom_range(0, 9) == 0);
            eret_in    = ($urandom_range(0, 7) == 0);
            mem_pc     = $urandom & 32'hFFFF_FFFC;
            epc_in     = $urandom;
            if ($urandom_range(0, 19) == 0) status_in = {$urandom, 1'b0} | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) irq_in = ~irq_in;
            step();
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i, dutVec(), expVec());
            end
        end
    endtask

    initial begin
        clearInputs();
        rst = 1;
        modelReset();
        test_reset();
        test_overflow();
        test_syscall_eret();
        test_irq_gating();
        test_simultaneous();
        test_stall();
        test_nesting();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt arbiter that sits directly upstream of CP0 and drives its exception inputs.
- Synchronises and latches the external interrupt line.
- Collects synchronous exceptions (syscall, unimplemented opcode, overflow) from the MEM stage and gates interrupts with Status.IE.
- Emits a one-cycle one-hot cause code, the EPC write strobe/value, a pipeline flush, and a PC redirect to the handler or, on ERET, back to EPC.
- Tracks exception nesting depth.

Parameters:
HANDLER_ADDR, 32'h0000_0080, PC loaded on any exception/interrupt entry
DEPTH_MAX, 7, maximum nesting depth (matches the 8-nibble Status stack)

Ports:
clk  in  1  clock, posedge
rst  in  1  reset, asynchronous, active-high
irq_in  in  1  external interrupt request, asynchronous to clk, level
mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
mem_pc  in  32  PC of the MEM-stage instruction
exc_sys  in  1  MEM instruction is SYSCALL
exc_unimpl  in  1  MEM instruction is unimplemented
exc_ovf  in  1  MEM instruction raised arithmetic overflow
eret_in  in  1  MEM instruction is ERET
pipe_stall  in  1  pipeline is stalled; no event may be taken
status_in  in  32  current CP0 Status (bit0 = IE)
epc_in  in  32  current CP0 EPC
sig_out  out  4  one-hot to CP0: [0] INT, [1] Sys, [2] Unimpl, [3] Ovf
epc_wr  out  1  EPC write strobe to CP0
epc_val  out  32  value for EPC
eret_out  out  1  ERET strobe to CP0
flush  out  1  squash IF/ID/EX/MEM
redirect  out  1  load redirect_pc into PC
redirect_pc  out  32  redirect target
irq_pending  out  1  latched, not yet serviced interrupt
depth  out  3  current nesting depth
nest_ovf  out  1  sticky: entry attempted at DEPTH_MAX

Behaviour:
Reset values:
- All outputs 0; state IDLE; sync flops, pending and depth cleared.
- Reset mid-TAKE/ERET aborts the pulse immediately (asynchronous).

Interrupt input:
- 2-flop synchroniser on irq_in, then rising-edge detect.
- A detected edge sets pending. Pending clears only when the INT event is taken.
- A new edge arriving while pending is already set is absorbed (no counting).
- irq_pending = pending.

States: IDLE, TAKE, ERET. Events are evaluated only in IDLE with pipe_stall=0 and mem_valid=1. Priority, highest first:
1. exc_ovf
2. exc_unimpl
3. exc_sys
4. eret_in
5. interrupt (pending & status_in[0])

IDLE -> TAKE on a synchronous exception or interrupt (posedge N). All outputs are registered and valid for exactly the cycle after N, so CP0 samples them at the following negedge:
- sig_out = one-hot of the winning event.
- epc_wr = 1.
- epc_val = mem_pc+4 for Sys; mem_pc for Unimpl, Ovf and INT (the MEM instruction is squashed and re-executed).
- flush = 1, redirect = 1, redirect_pc = HANDLER_ADDR.
- depth increments, saturating at DEPTH_MAX. If depth = DEPTH_MAX at entry, nest_ovf sets (sticky until rst); the entry still proceeds.
- An INT entry clears pending.

IDLE -> ERET on eret_in (no higher-priority event):
- Next cycle: eret_out = 1, flush = 1, redirect = 1, redirect_pc = epc_in as sampled at posedge N.
- sig_out = 0, epc_wr = 0.
- depth decrements, floor 0.

TAKE/ERET -> IDLE unconditionally after one cycle. All inputs are ignored in TAKE/ERET (the pipeline is being flushed). Pending may still set during these states.

Simultaneous and boundary cases:
- Interrupt coinciding with ERET: ERET wins; the interrupt stays pending and is re-evaluated against the restored IE.
- Interrupt with IE=0: held pending indefinitely.
- mem_valid=0 or pipe_stall=1: no event is taken; the request persists while its inputs remain asserted.
- More than one exc_* asserted: the highest priority wins; only that bit appears in sig_out.

Test Plan:
- Overflow: mem_pc=0x100, exc_ovf=1 -> next cycle sig_out=4'b1000, epc_wr=1, epc_val=0x100, flush=redirect=1, redirect_pc=0x80, depth=1; back to IDLE one cycle later.
- Syscall: mem_pc=0x200 -> sig_out=4'b0010, epc_val=0x204. Then eret_in with epc_in=0x204 -> eret_out=1, redirect_pc=0x204, depth=0.
- Interrupt gating: irq_in pulse with status_in=0 -> irq_pending=1 three cycles later, no event. Set status_in[0]=1 with mem_valid=1, mem_pc=0x300 -> sig_out=4'b0001, epc_val=0x300, irq_pending=0.
- Simultaneous events: exc_ovf & exc_sys -> only 4'b1000. Pending IRQ (IE=1) plus eret_in -> ERET taken, irq_pending stays 1. pipe_stall=1 with exc_ovf -> no output until stall drops.
- Nesting: 8 consecutive syscalls without ERET -> depth saturates at 7, nest_ovf=1 after the 8th. Assert rst mid-TAKE -> all outputs 0 immediately, depth=0, nest_ovf=0.
